// File: rtl/tcdm_error_slave_if.sv
// TCDM request/response bus bundle for the error slave.
interface tcdm_error_slave_if;
  logic        req_i;
  logic [31:0] add_i;
  logic        wen_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o;
  logic        r_valid_o;
  logic [31:0] r_rdata_o;
  logic        r_opc_o;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i,
    output gnt_o, r_valid_o, r_rdata_o, r_opc_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i,
    input  gnt_o, r_valid_o, r_rdata_o, r_opc_o
  );
endinterface

// File: rtl/tcdm_error_slave.sv
// TCDM slave that grants everything, answers every access with an error response,
// logs the first errored access and counts all of them.
module tcdm_error_slave #(
  parameter int unsigned RESP_LATENCY = 1,
  parameter logic [31:0] ERR_RDATA    = 32'hBADACCE5,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tcdm_error_slave_if.slave    bus,
  input  logic                 clr_i,
  output logic                 err_valid_o,
  output logic [31:0]          err_addr_o,
  output logic                 err_wen_o,
  output logic [3:0]           err_be_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 err_irq_o
);

  typedef enum logic {IDLE, LOGGED} state_e;

  state_e                  state_q, state_d;
  logic [RESP_LATENCY-1:0] vld_q, vld_d;
  logic [31:0]             addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [3:0]              be_q, be_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    irq_q, irq_d;
  logic                    txn;
  logic                    unused_wdata;

  assign txn          = bus.req_i & ~rst_i;
  assign unused_wdata = ^bus.wdata_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    irq_d   = 1'b0;

    vld_d    = '0;
    vld_d[0] = txn;
    for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    // A clear coinciding with a transaction restarts the log with that transaction.
    if (txn && (state_q == IDLE || clr_i)) begin
      state_d = LOGGED;
      addr_d  = bus.add_i;
      wen_d   = bus.wen_i;
      be_d    = bus.be_i;
      irq_d   = 1'b1;
    end else if (clr_i) begin
      state_d = IDLE;
      addr_d  = '0;
      wen_d   = 1'b0;
      be_d    = '0;
    end

    if (clr_i) begin
      cnt_d = txn ? CNT_WIDTH'(1) : '0;
    end else if (txn && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vld_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      be_q    <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  // Outputs are forced low for the whole reset window, including its first cycle.
  assign bus.gnt_o     = txn;
  assign bus.r_valid_o = vld_q[RESP_LATENCY-1] & ~rst_i;
  assign bus.r_rdata_o = bus.r_valid_o ? ERR_RDATA : '0;
  assign bus.r_opc_o   = bus.r_valid_o;

  assign err_valid_o = (state_q == LOGGED) & ~rst_i;
  assign err_addr_o  = rst_i ? '0 : addr_q;
  assign err_wen_o   = wen_q & ~rst_i;
  assign err_be_o    = rst_i ? '0 : be_q;
  assign err_cnt_o   = rst_i ? '0 : cnt_q;
  assign err_irq_o   = irq_q & ~rst_i;

endmodule

// File: doc/tcdm_error_slave.md
TCDM_ERROR_SLAVE -- requirements
Module: tcdm_error_slave

Interface
REQ-001 Parameter RESP_LATENCY, default 1, SHALL set the cycles from grant to response; legal range 1..4.
REQ-002 Parameter ERR_RDATA, default 32'hBADACCE5, SHALL be the value returned on every response.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the width of the error counter; legal range 2..32.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The ports SHALL be as follows:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  TCDM request.
- add_i  in  32  request address.
- wen_i  in  1  TCDM write enable: 1=read, 0=write.
- wdata_i  in  32  write data; ignored.
- be_i  in  4  byte enables; captured only.
- gnt_o  out  1  grant.
- r_valid_o  out  1  response valid.
- r_rdata_o  out  32  response data.
- r_opc_o  out  1  response error flag.
- clr_i  in  1  clear log and counter.
- err_valid_o  out  1  first-error log holds a valid entry.
- err_addr_o  out  32  address of first logged error.
- err_wen_o  out  1  wen of first logged error.
- err_be_o  out  4  be of first logged error.
- err_cnt_o  out  CNT_WIDTH  number of errored transactions.
- err_irq_o  out  1  one-cycle interrupt pulse on a new first error.

Function
REQ-006 gnt_o SHALL equal req_i combinationally when not in reset; the block SHALL never stall.
REQ-007 A transaction SHALL be any cycle with req_i=1 and gnt_o=1, read or write alike.
REQ-008 r_valid_o SHALL assert exactly RESP_LATENCY cycles after each transaction, for one cycle per transaction.
REQ-009 The response pipeline SHALL be a RESP_LATENCY-deep valid shift register, so back-to-back transactions produce back-to-back responses with no loss.
REQ-010 While r_valid_o=1, r_rdata_o SHALL be ERR_RDATA and r_opc_o SHALL be 1; otherwise both SHALL be 0.
REQ-011 Log FSM states SHALL be IDLE and LOGGED; err_valid_o=1 exactly in LOGGED.
REQ-012 IDLE->LOGGED SHALL occur on a transaction, registering add_i, wen_i and be_i into err_addr_o, err_wen_o and err_be_o.
REQ-013 In LOGGED, further transactions SHALL NOT modify err_addr_o, err_wen_o or err_be_o.
REQ-014 LOGGED->IDLE SHALL occur on clr_i=1 with no transaction in the same cycle.
REQ-015 err_irq_o SHALL pulse for one cycle, the cycle after each IDLE->LOGGED entry.
REQ-016 err_cnt_o SHALL increment by 1 per transaction and saturate at all-ones (no wrap).
REQ-017 With clr_i=1 alone, next cycle: err_cnt_o=0, err_valid_o=0, captured fields=0.
REQ-018 With clr_i=1 and a transaction in the same cycle, the new transaction SHALL win:
- FSM goes to LOGGED, capturing the new transaction's fields.
- err_cnt_o=1.
- err_irq_o pulses.
REQ-019 clr_i SHALL NOT affect in-flight responses.

Reset
REQ-020 While rst_i=1:
- gnt_o=0, r_valid_o=0, r_rdata_o=0, r_opc_o=0, err_irq_o=0.
- err_valid_o=0, err_addr_o=0, err_wen_o=0, err_be_o=0, err_cnt_o=0.
- FSM=IDLE.
REQ-021 Reset mid-operation SHALL flush the response pipeline; no response from a pre-reset transaction SHALL appear after reset.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Single read, add_i=32'h1A10_0004, RESP_LATENCY=1 -> gnt_o same cycle; next cycle r_valid_o=1, r_rdata_o=32'hBADACCE5, r_opc_o=1; err_addr_o=32'h1A10_0004, err_irq_o one pulse, err_cnt_o=1.
- 5 back-to-back writes, RESP_LATENCY=3 -> 5 consecutive r_valid_o cycles starting 3 cycles after the first grant; err_wen_o=0; err_addr_o holds the first address; err_cnt_o=5; exactly one err_irq_o pulse.
- CNT_WIDTH=2, 6 transactions -> err_cnt_o sequence 1,2,3,3,3,3.
- clr_i coincident with a transaction at add_i=32'h0000_0040 while LOGGED with err_cnt_o=4 -> err_addr_o=32'h40, err_cnt_o=1, err_irq_o pulses; clr_i alone next -> err_valid_o=0, err_cnt_o=0.
- rst_i asserted 1 cycle after a grant with RESP_LATENCY=2 -> no r_valid_o ever appears for that transaction; all outputs 0 during and after reset.
